// File: rtl/inst_buffer_if.sv
// Fetch/decode-side bundle for the instruction buffer.
// master = fetch/decode environment, slave = inst_buffer.
interface inst_buffer_if #(
    parameter int unsigned PTR_W = 5
);
    logic              flush_i;
    logic [1:0]        fetch_num_i;
    logic [31:0]       fetch_inst1_i;
    logic [31:0]       fetch_addr1_i;
    logic [31:0]       fetch_inst2_i;
    logic [31:0]       fetch_addr2_i;
    logic              buffer_full_o;
    logic              issue_i;
    logic              issued_i;
    logic              issue_en_o;
    logic [31:0]       inst1_o;
    logic [31:0]       inst1_addr_o;
    logic [31:0]       inst2_o;
    logic [31:0]       inst2_addr_o;
    logic [PTR_W:0]    occupancy_o;
    logic [31:0]       stall_cnt_o;

    modport master (
        output flush_i, fetch_num_i, fetch_inst1_i, fetch_addr1_i,
               fetch_inst2_i, fetch_addr2_i, issue_i, issued_i,
        input  buffer_full_o, issue_en_o, inst1_o, inst1_addr_o,
               inst2_o, inst2_addr_o, occupancy_o, stall_cnt_o
    );

    modport slave (
        input  flush_i, fetch_num_i, fetch_inst1_i, fetch_addr1_i,
               fetch_inst2_i, fetch_addr2_i, issue_i, issued_i,
        output buffer_full_o, issue_en_o, inst1_o, inst1_addr_o,
               inst2_o, inst2_addr_o, occupancy_o, stall_cnt_o
    );
endinterface

// File: rtl/inst_buffer.sv
// Circular dual-push / dual-pop instruction FIFO between fetch and decode.
// Optional feature macro: IBUF_STALL_CNT_EN (decode-starvation cycle counter).
module inst_buffer #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned PTR_W = 5
) (
    input  logic         clk,
    input  logic         rst,
    inst_buffer_if.slave bus
);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] head_p1;
    logic [PTR_W-1:0] tail_p1;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [1:0]       push_num_c;
    logic [1:0]       push_acc_c;
    logic [1:0]       pop_req_c;
    logic [1:0]       pop_act_c;
    logic [31:0]      inst_mem [DEPTH];
    logic [31:0]      addr_mem [DEPTH];

    assign head_p1 = head + PTR_W'(1);
    assign tail_p1 = tail + PTR_W'(1);

    // Push is all-or-nothing against pre-pop occupancy; pop is clamped to what is held.
    always_comb begin
        push_num_c = (bus.fetch_num_i == 2'd3) ? 2'd0 : bus.fetch_num_i;
        push_acc_c = 2'd0;
        if ((CNT_W'(DEPTH) - count) >= CNT_W'(push_num_c)) begin
            push_acc_c = push_num_c;
        end
        pop_req_c = 2'd0;
        if (bus.issued_i) begin
            pop_req_c = bus.issue_i ? 2'd2 : 2'd1;
        end
        pop_act_c = pop_req_c;
        if (CNT_W'(pop_req_c) > count) begin
            pop_act_c = count[1:0];
        end
        count_next = count + CNT_W'(push_acc_c) - CNT_W'(pop_act_c);
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(pop_act_c);
            tail  <= tail + PTR_W'(push_acc_c);
            count <= count_next;
        end
    end

    // Storage carries no reset; stale slots are masked by count.
    always_ff @(posedge clk) begin
        if (!rst && !bus.flush_i) begin
            if (push_acc_c != 2'd0) begin
                inst_mem[tail] <= bus.fetch_inst1_i;
                addr_mem[tail] <= bus.fetch_addr1_i;
            end
            if (push_acc_c == 2'd2) begin
                inst_mem[tail_p1] <= bus.fetch_inst2_i;
                addr_mem[tail_p1] <= bus.fetch_addr2_i;
            end
        end
    end

    always_comb begin
        bus.inst1_o      = 32'd0;
        bus.inst1_addr_o = 32'd0;
        bus.inst2_o      = 32'd0;
        bus.inst2_addr_o = 32'd0;
        if (count != CNT_W'(0)) begin
            bus.inst1_o      = inst_mem[head];
            bus.inst1_addr_o = addr_mem[head];
        end
        if (count >= CNT_W'(2)) begin
            bus.inst2_o      = inst_mem[head_p1];
            bus.inst2_addr_o = addr_mem[head_p1];
        end
        bus.occupancy_o   = count;
        bus.buffer_full_o = (count > CNT_W'(DEPTH - 2));
        bus.issue_en_o    = (count >= CNT_W'(2));
    end

`ifdef IBUF_STALL_CNT_EN
    logic [31:0] stall_cnt;

    // Counts cycles where decode cannot dual-issue; saturates, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 32'd0;
        end else if (!bus.flush_i && !bus.issue_en_o && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign bus.stall_cnt_o = stall_cnt;
`else
    assign bus.stall_cnt_o = 32'd0;
`endif

endmodule
